// File: rtl/button_press_classifier_if.sv
// Button front-end bundle: raw button in, classified press code and debounced level out.
interface button_press_classifier_if;
  logic       buttonIn;
  logic [1:0] buttonState;
  logic       pressed;

  modport master (output buttonIn, input buttonState, input pressed);
  modport slave  (input buttonIn, output buttonState, output pressed);
endinterface

// File: rtl/button_press_classifier.sv
// Synchronises and debounces the setting pushbutton and classifies each press as
// short (code 1) or long (code 2), reported as a single-cycle pulse on buttonState.
module button_press_classifier #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 150_000_000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  button_press_classifier_if.slave bus
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic              REL_LVL   = BTN_ACTIVE_LOW;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_REL_S,
    LONG_HELD,
    DEB_REL_L
  } state_t;

  state_t              state, state_n;
  logic [1:0]          sync;
  logic                p;
  logic [DEB_W-1:0]    deb_cnt, deb_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n, hold_inc;
  logic [1:0]          code_q, code_n;

  assign p = BTN_ACTIVE_LOW ? ~sync[1] : sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= {2{REL_LVL}};
      state    <= IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      code_q   <= '0;
    end else begin
      sync     <= {sync[0], bus.buttonIn};
      state    <= state_n;
      deb_cnt  <= deb_n;
      hold_cnt <= hold_n;
      code_q   <= code_n;
    end
  end

  // Hold counter saturates so a stuck button can never wrap into a second long code.
  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);

  always_comb begin
    state_n = state;
    deb_n   = deb_cnt;
    hold_n  = hold_cnt;
    code_n  = '0;
    case (state)
      IDLE: begin
        if (p) begin
          state_n = DEB_PRESS;
          deb_n   = '0;
          hold_n  = '0;
        end
      end
      DEB_PRESS: begin
        hold_n = hold_inc;
        if (!p)                    state_n = IDLE;
        else if (deb_cnt == DEB_LAST) state_n = HELD;
        else                       deb_n = deb_cnt + DEB_W'(1);
      end
      HELD: begin
        if (!p) begin
          state_n = DEB_REL_S;
          deb_n   = '0;
        end else begin
          hold_n = hold_inc;
          if (hold_cnt == HOLD_LAST) begin
            state_n = LONG_HELD;
            code_n  = 2'd2;
          end
        end
      end
      // A release bounce returns to HELD with hold_cnt untouched, so the press keeps its age.
      DEB_REL_S: begin
        if (p)                     state_n = HELD;
        else if (deb_cnt == DEB_LAST) begin
          state_n = IDLE;
          code_n  = 2'd1;
        end else                   deb_n = deb_cnt + DEB_W'(1);
      end
      LONG_HELD: begin
        if (!p) begin
          state_n = DEB_REL_L;
          deb_n   = '0;
        end
      end
      DEB_REL_L: begin
        if (p)                     state_n = LONG_HELD;
        else if (deb_cnt == DEB_LAST) state_n = IDLE;
        else                       deb_n = deb_cnt + DEB_W'(1);
      end
      default: begin
        state_n = IDLE;
        deb_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  assign bus.buttonState = code_q;
  assign bus.pressed     = (state == HELD) || (state == DEB_REL_S) ||
                           (state == LONG_HELD) || (state == DEB_REL_L);

endmodule
